// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller and the
// pipeline buffers it drives.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        HALT     = 2'd2
    } state_e;

    localparam int REG_IDX_W = 6;
    localparam int CTRL_W    = 9;

    // Every control output of pipe_ctrl in one word.
    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic memwb_flush;
        logic halted;
    } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare between the instruction in ID and a load in EX.
// Purely combinational so a forwarding unit can reuse it.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_IDX_W-1:0] id_rs_i,
    input  logic [REG_IDX_W-1:0] id_rt_i,
    input  logic                 id_uses_rs_i,
    input  logic                 id_uses_rt_i,
    input  logic [REG_IDX_W-1:0] ex_rd_i,
    input  logic                 ex_mem_read_i,
    output logic                 load_use_o
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = id_uses_rs_i && (id_rs_i == ex_rd_i);
    assign rt_hit = id_uses_rt_i && (id_rt_i == ex_rd_i);

    // Register 0 is hard-wired, so a load targeting it never creates a hazard.
    assign load_use_o = ex_mem_read_i && (ex_rd_i != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: stage enables/flushes for load-use,
// taken branches, data-memory wait states and memory-timeout halt.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] id_rs_i,
    input  logic [REG_IDX_W-1:0] id_rt_i,
    input  logic                 id_uses_rs_i,
    input  logic                 id_uses_rt_i,
    input  logic [REG_IDX_W-1:0] ex_rd_i,
    input  logic                 ex_mem_read_i,
    input  logic                 ex_branch_taken_i,
    input  logic                 mem_req_i,
    input  logic                 mem_ready_i,
    output logic                 pc_en_o,
    output logic                 ifid_en_o,
    output logic                 idex_en_o,
    output logic                 exmem_en_o,
    output logic                 memwb_en_o,
    output logic                 ifid_flush_o,
    output logic                 idex_flush_o,
    output logic                 memwb_flush_o,
    output logic                 halted_o,
    output logic [CNT_W-1:0]     stall_cnt_o,
    output logic [CNT_W-1:0]     flush_cnt_o
);

    localparam logic [7:0] TIMEOUT_CMP = 8'(MEM_TIMEOUT);

    state_e           state_q, state_d;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
    logic             mem_stall;
    logic             load_use;
    ctrl_t            ctrl;

    assign mem_stall = mem_req_i && !mem_ready_i;

    hazard_detect u_hazard_detect (
        .id_rs_i       (id_rs_i),
        .id_rt_i       (id_rt_i),
        .id_uses_rs_i  (id_uses_rs_i),
        .id_uses_rt_i  (id_uses_rt_i),
        .ex_rd_i       (ex_rd_i),
        .ex_mem_read_i (ex_mem_read_i),
        .load_use_o    (load_use)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                    wait_d  = 8'd1;
                end
            end
            MEM_WAIT: begin
                // A dropped request releases the wait just like mem_ready.
                if (!mem_stall) begin
                    state_d = RUN;
                    wait_d  = '0;
                end else if (wait_q == TIMEOUT_CMP) begin
                    state_d = HALT;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            HALT:    state_d = HALT;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        ctrl = ctrl_t'({CTRL_W{1'b0}});
        if (!rst_n) begin
            // Bubble every reset-less buffer while the PC is held.
            ctrl.ifid_en     = 1'b1;
            ctrl.idex_en     = 1'b1;
            ctrl.exmem_en    = 1'b1;
            ctrl.memwb_en    = 1'b1;
            ctrl.ifid_flush  = 1'b1;
            ctrl.idex_flush  = 1'b1;
            ctrl.memwb_flush = 1'b1;
        end else if (state_q == HALT) begin
            ctrl.halted = 1'b1;
        end else if (mem_stall) begin
            ctrl.memwb_en    = 1'b1;
            ctrl.memwb_flush = 1'b1;
        end else begin
            ctrl.pc_en    = 1'b1;
            ctrl.ifid_en  = 1'b1;
            ctrl.idex_en  = 1'b1;
            ctrl.exmem_en = 1'b1;
            ctrl.memwb_en = 1'b1;
            // A taken branch squashes the ID instruction, masking any load-use.
            if (ex_branch_taken_i) begin
                ctrl.ifid_flush = 1'b1;
                ctrl.idex_flush = 1'b1;
            end else if (load_use) begin
                ctrl.pc_en      = 1'b0;
                ctrl.ifid_en    = 1'b0;
                ctrl.idex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!ctrl.pc_en && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (ctrl.ifid_flush && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign pc_en_o       = ctrl.pc_en;
    assign ifid_en_o     = ctrl.ifid_en;
    assign idex_en_o     = ctrl.idex_en;
    assign exmem_en_o    = ctrl.exmem_en;
    assign memwb_en_o    = ctrl.memwb_en;
    assign ifid_flush_o  = ctrl.ifid_flush;
    assign idex_flush_o  = ctrl.idex_flush;
    assign memwb_flush_o = ctrl.memwb_flush;
    assign halted_o      = ctrl.halted;
    assign stall_cnt_o   = stall_cnt_q;
    assign flush_cnt_o   = flush_cnt_q;

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the 5-stage CPU. It drives the load-enable and flush inputs of the PC register and the IF/ID, ID/EX, EX/MEM and MEM/WB buffers. It resolves load-use hazards, taken-branch flushes and data-memory wait states, and halts the pipe on a memory timeout. It sits beside the datapath and has no data path of its own; it sees only register indices and handshake/status bits.

## Interface
Parameters:
- MEM_TIMEOUT, 255: max MEM_WAIT count before halt (8-bit compare)
- CNT_W, 16: width of performance counters

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- id_rs, id_rt  in  6  source register indices of the instruction in ID
- id_uses_rs, id_uses_rt  in  1  ID instruction actually reads rs / rt
- ex_rd  in  6  destination index of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  branch resolved taken in EX
- mem_req  in  1  MEM stage is accessing data memory this cycle
- mem_ready  in  1  data memory completes the access this cycle
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  stage load enables
- ifid_flush, idex_flush, memwb_flush  out  1  load bubble (ctrl=0) on next edge; flush overrides en
- halted  out  1  sticky memory-timeout halt
- stall_cnt, flush_cnt  out  CNT_W  saturating performance counters

## Operation
- FSM states: RUN, MEM_WAIT, HALT. Reset state: RUN. wait_cnt (8 bit) = 0.
- All enable and flush outputs are combinational from state and inputs. The counters, state and wait_cnt are registered.
- mem_stall = mem_req & !mem_ready.
- load_use = ex_mem_read & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- Priority, highest first: mem_stall, then ex_branch_taken, then load_use, then normal.
  - mem_stall (RUN or MEM_WAIT): pc/ifid/idex/exmem en=0; memwb_flush=1; all other flushes 0.
  - Branch taken: all en=1; ifid_flush=1, idex_flush=1. A simultaneous load_use is ignored because the ID instruction is squashed.
  - load_use: pc_en=0, ifid_en=0; idex_flush=1; exmem/memwb en=1.
  - Normal: all en=1, flushes 0.
- Transitions:
  - RUN with mem_stall goes to MEM_WAIT and sets wait_cnt<=1.
  - MEM_WAIT with mem_ready goes to RUN and clears wait_cnt. Outputs that cycle follow the branch/load_use/normal rules.
  - MEM_WAIT with !mem_ready: if wait_cnt==MEM_TIMEOUT, go to HALT; otherwise wait_cnt+1.
  - MEM_WAIT with mem_req dropped is treated as ready.
  - HALT: all en=0, all flushes 0, halted=1. HALT exits only via rst_n.
- A branch that coincides with mem_stall is not lost. EX is frozen, so ex_branch_taken persists and the flush applies on the release cycle.
- stall_cnt increments every cycle with pc_en=0 outside reset, including HALT. flush_cnt increments every cycle with ifid_flush=1. Both saturate at all-ones.

## Timing
- Zero-cycle latency: outputs respond in the same cycle as their inputs. Buffers act on the next rising edge.
- Load-use inserts exactly one bubble. On the following cycle ex_mem_read is 0 in EX, so normal flow resumes.
- Taken branch costs 2 squashed instructions.
- Timeout: with mem_stall held from cycle 0, HALT is entered after MEM_TIMEOUT+1 stalled cycles.
- While rst_n=0:
  - pc_en=0; ifid_flush, idex_flush and memwb_flush=1; all other en=1. This clears the reset-less buffers.
  - halted=0; counters=0; state=RUN.
- Reset mid-MEM_WAIT or during HALT returns to RUN immediately (asynchronous).

## Structure
- Shared package pipe_ctrl_pkg:
  - state encoding (RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2)
  - REG_IDX_W=6 (shared with the pipeline buffers)
  - CTRL_W=9
- One sub-module, hazard_detect: purely combinational load_use compare, reusable by a future forwarding unit.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs=5, id_uses_rs=1 for 1 cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle; stall_cnt=1.
- rd zero: same as above but ex_rd=0, id_rs=0 -> no stall; all en=1.
- Branch and load_use together: ex_branch_taken=1 and the load_use condition both true -> ifid_flush=1, idex_flush=1, pc_en=1; flush_cnt=1.
- Memory wait with branch: mem_req=1, mem_ready=0 for 3 cycles while ex_branch_taken=1 -> 3 cycles of pc/ifid/idex/exmem en=0 and memwb_flush=1. Then on mem_ready=1: ifid_flush=idex_flush=1; state returns to RUN.
- Timeout: MEM_TIMEOUT=4, mem_req=1, mem_ready=0 held -> halted=1 from cycle 5. All en=0 thereafter, even after mem_ready=1.
- Async reset while in HALT: rst_n low mid-cycle -> halted=0 immediately; flushes=1, pc_en=0; counters read 0.
